// File: rtl/fft_r4_engine_if.sv
// Peripheral bus bundle between the CPU side (master) and the FFT engine (slave).
interface fft_r4_engine_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (output per_addr, per_din, per_en, per_we, input per_dout);
    modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/fft_r4_engine.sv
// Radix-4 butterfly engine: CPU fills inbuf, START runs NCH channels through a
// 2-stage butterfly (one channel per cycle), results are read back from outbuf.
module fft_r4_engine #(
    parameter int          DW        = 16,
    parameter int          NCH       = 4,
    parameter logic [13:0] BASE_ADDR = 14'h88
) (
    input  logic           mclk,
    input  logic           puc_rst_n,
    fft_r4_engine_if.slave bus
);
    localparam int DEPTH = NCH * 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(NCH + 1);
    localparam logic signed [DW+1:0] XMAX = (DW+2)'((2**(DW-1)) - 1);
    localparam logic signed [DW+1:0] XMIN = (DW+2)'(-(2**(DW-1)));

    typedef enum logic {IDLE, RUN} state_e;
    state_e state_q, state_d;

    logic signed [DW-1:0] inbuf_q  [2**AW];
    logic signed [DW-1:0] outbuf_q [2**AW];
    logic [AW-1:0] in_ptr_q, out_ptr_q, rd_base_q, s1_base_q;
    logic [CW-1:0] iss_cnt_q;
    logic          scale_q, run_scale_q, done_q, ovf_q, err_q;
    logic          s1_vld_q, s1_last_q;
    // s order: s0r,s0i,s1r,s1i,s2r,s2i,s3r,s3i
    logic signed [DW:0]   s_q [8];
    logic signed [DW:0]   s_d [8];
    logic signed [DW+1:0] x   [8];
    logic signed [DW-1:0] y   [8];
    logic [7:0]           clip;

    function automatic logic signed [DW:0] w1(input logic signed [DW-1:0] v);
        return {v[DW-1], v};
    endfunction
    function automatic logic signed [DW+1:0] w2(input logic signed [DW:0] v);
        return {v[DW], v};
    endfunction
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [13:0] off;
    logic hit, wr, rd, busy, wr_ctrl, start, clr, issue, fin;
    logic wr_inptr, wr_din, wr_outptr, rd_dout;

    assign off       = bus.per_addr - BASE_ADDR;
    assign hit       = bus.per_en && (off < 14'd6);
    assign wr        = hit && (bus.per_we == 2'b11);
    assign rd        = hit && (bus.per_we == 2'b00);
    assign busy      = (state_q == RUN);
    assign wr_ctrl   = wr && (off == 14'd0);
    assign clr       = wr_ctrl && bus.per_din[2];
    assign start     = wr_ctrl && bus.per_din[0] && !bus.per_din[2] && !busy;
    assign wr_inptr  = wr && (off == 14'd2);
    assign wr_din    = wr && (off == 14'd3);
    assign wr_outptr = wr && (off == 14'd4);
    assign rd_dout   = rd && (off == 14'd5);
    assign issue     = busy && (iss_cnt_q < CW'(NCH));
    assign fin       = s1_vld_q && s1_last_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (fin)   state_d = IDLE;
        endcase
        if (clr) state_d = IDLE;
    end

    // Stage 1: A+/-C and B+/-D for the channel addressed by rd_base_q
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            s_d[c]   = w1(inbuf_q[rd_base_q + AW'(c)])     + w1(inbuf_q[rd_base_q + AW'(4 + c)]);
            s_d[2+c] = w1(inbuf_q[rd_base_q + AW'(c)])     - w1(inbuf_q[rd_base_q + AW'(4 + c)]);
            s_d[4+c] = w1(inbuf_q[rd_base_q + AW'(2 + c)]) + w1(inbuf_q[rd_base_q + AW'(6 + c)]);
            s_d[6+c] = w1(inbuf_q[rd_base_q + AW'(2 + c)]) - w1(inbuf_q[rd_base_q + AW'(6 + c)]);
        end
    end

    // Stage 2 combines, then either floor-divides by 4 or saturates to DW bits
    always_comb begin
        x[0] = w2(s_q[0]) + w2(s_q[4]);
        x[1] = w2(s_q[1]) + w2(s_q[5]);
        x[2] = w2(s_q[2]) + w2(s_q[7]);
        x[3] = w2(s_q[3]) - w2(s_q[6]);
        x[4] = w2(s_q[0]) - w2(s_q[4]);
        x[5] = w2(s_q[1]) - w2(s_q[5]);
        x[6] = w2(s_q[2]) - w2(s_q[7]);
        x[7] = w2(s_q[3]) + w2(s_q[6]);
        for (int j = 0; j < 8; j++) begin
            clip[j] = 1'b0;
            y[j]    = x[j][DW-1:0];
            if (run_scale_q) begin
                y[j] = x[j][DW+1:2];
            end else if (x[j] > XMAX) begin
                y[j]    = {1'b0, {(DW-1){1'b1}}};
                clip[j] = 1'b1;
            end else if (x[j] < XMIN) begin
                y[j]    = {1'b1, {(DW-1){1'b0}}};
                clip[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < 2**AW; i++) begin
                inbuf_q[i]  <= '0;
                outbuf_q[i] <= '0;
            end
            in_ptr_q    <= '0;
            out_ptr_q   <= '0;
            rd_base_q   <= '0;
            s1_base_q   <= '0;
            iss_cnt_q   <= '0;
            scale_q     <= 1'b0;
            run_scale_q <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s_q         <= '{default: '0};
        end else begin
            state_q <= state_d;
            if (wr_ctrl) scale_q <= bus.per_din[1];
            if (clr) begin
                done_q    <= 1'b0;
                ovf_q     <= 1'b0;
                err_q     <= 1'b0;
                in_ptr_q  <= '0;
                out_ptr_q <= '0;
                s1_vld_q  <= 1'b0;
            end else begin
                if (start) begin
                    run_scale_q <= bus.per_din[1];
                    done_q      <= 1'b0;
                    ovf_q       <= 1'b0;
                    iss_cnt_q   <= '0;
                    rd_base_q   <= '0;
                end
                s1_vld_q <= issue;
                if (issue) begin
                    s_q       <= s_d;
                    s1_base_q <= rd_base_q;
                    s1_last_q <= (iss_cnt_q == CW'(NCH - 1));
                    iss_cnt_q <= iss_cnt_q + 1'b1;
                    rd_base_q <= rd_base_q + AW'(8);
                end
                if (s1_vld_q) begin
                    for (int j = 0; j < 8; j++) outbuf_q[s1_base_q + AW'(j)] <= y[j];
                    if (|clip) ovf_q <= 1'b1;
                end
                if (fin) done_q <= 1'b1;
                // Buffer access is locked out for the whole run
                if (busy) begin
                    if (wr_din || rd_dout) err_q <= 1'b1;
                end else begin
                    if (wr_inptr)  in_ptr_q  <= bus.per_din[AW-1:0];
                    if (wr_outptr) out_ptr_q <= bus.per_din[AW-1:0];
                    if (wr_din) begin
                        inbuf_q[in_ptr_q] <= DW'($signed(bus.per_din));
                        in_ptr_q          <= ptr_inc(in_ptr_q);
                    end
                    if (rd_dout) out_ptr_q <= ptr_inc(out_ptr_q);
                end
            end
        end
    end

    always_comb begin
        bus.per_dout = '0;
        if (rd) begin
            case (off[2:0])
                3'd0:    bus.per_dout = {14'b0, scale_q, 1'b0};
                3'd1:    bus.per_dout = {12'b0, err_q, ovf_q, done_q, busy};
                3'd2:    bus.per_dout = 16'(in_ptr_q);
                3'd4:    bus.per_dout = 16'(out_ptr_q);
                3'd5:    bus.per_dout = busy ? 16'h0 : 16'(outbuf_q[out_ptr_q]);
                default: bus.per_dout = '0;
            endcase
        end
    end
endmodule
